// File: rtl/qpsk_packet_writer.sv
// qpsk_packet_writer: QPSK TX framer, BRAM symbols -> AXI-Stream frame (P0,P1,P2,P3, zeros, Gray-mapped data).
// Define PACKET_WRITER_IDLE_FILL_EN to stream zero samples with tvalid=1 while idle.
module qpsk_packet_writer #(
   parameter int C_M00_AXIS_TDATA_WIDTH = 32,
   parameter int BRAM_BITDEPTH = 16,
   parameter int BRAM_BITWIDTH = 2,
   parameter int AMPLITUDE = 16384,
   parameter int NUM_ZEROS = 4
) (
   input  logic m00_axis_aclk,
   input  logic m00_axis_aresetn,
   input  logic m00_axis_tready,
   output logic m00_axis_tvalid,
   output logic m00_axis_tlast,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
   output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
   output logic [BRAM_BITDEPTH-1:0] bram_addr,
   output logic bram_en,
   input  logic [BRAM_BITWIDTH-1:0] bram_douta,
   input  logic start,
   input  logic [31:0] num_samples,
   input  logic [31:0] data_len,
   input  logic [31:0] preamble_p1,
   output logic busy,
   output logic done
);
`ifdef PACKET_WRITER_IDLE_FILL_EN
   localparam logic FILL = 1'b1;
`else
   localparam logic FILL = 1'b0;
`endif
   localparam logic [15:0] POS = 16'(AMPLITUDE);
   localparam logic [15:0] NEG = 16'(-AMPLITUDE);
   localparam logic [31:0] P0 = {POS, 16'h0000};
   localparam logic [31:0] ZLAST = 32'(NUM_ZEROS - 1);
   typedef enum logic [2:0] {IDLE, PRE0, PRE1, PRE2, PRE3, ZEROS, DATA} state_t;
   state_t state, state_n;
   logic [31:0] samp, samp_n, sym, sym_n, n_q, n_n, len_q, len_n, p1_q, p1_n, rd_cnt;
   logic [C_M00_AXIS_TDATA_WIDTH-1:0] tdata_n;
   logic tvalid_n, tlast_n, busy_n, done_n, go, go_n;
   logic hs, load_ok, accept, last_samp, cons, pend;
   logic [1:0] cnt, occ;
   logic [BRAM_BITWIDTH-1:0] b0, b1, head;

   function automatic logic [31:0] to_iq(input logic [BRAM_BITWIDTH-1:0] s);
      return {s[1] ? NEG : POS, s[0] ? NEG : POS};
   endfunction

   assign m00_axis_tstrb = '1;

   // The output register holds the beat described by state/samp/sym; a new beat loads when it is free.
   always_comb begin
      hs = m00_axis_tvalid && m00_axis_tready;
      load_ok = !m00_axis_tvalid || m00_axis_tready;
      accept = state == IDLE && !go && start && data_len != 32'd0;
      last_samp = samp == n_q - 32'd1;
      head = cnt != 2'd0 ? b0 : bram_douta;
      state_n = state;
      samp_n = samp;
      sym_n = sym;
      n_n = accept ? (num_samples == 32'd0 ? 32'd1 : num_samples) : n_q;
      len_n = accept ? data_len : len_q;
      p1_n = accept ? preamble_p1 : p1_q;
      go_n = go;
      busy_n = busy || accept;
      done_n = hs && m00_axis_tlast;
      tvalid_n = m00_axis_tvalid;
      tdata_n = m00_axis_tdata;
      cons = 1'b0;
      if (state == IDLE) begin
         if ((accept || go) && load_ok) begin
            state_n = PRE0;
            samp_n = '0;
            sym_n = '0;
            tvalid_n = 1'b1;
            tdata_n = P0;
            go_n = 1'b0;
         end else begin
            go_n = go || accept;
            tvalid_n = load_ok ? FILL : m00_axis_tvalid;
            tdata_n = load_ok ? '0 : m00_axis_tdata;
         end
      end else if (hs) begin
         samp_n = last_samp ? 32'd0 : samp + 32'd1;
         if (last_samp)
            case (state)
               PRE0: begin
                  state_n = PRE1;
                  tdata_n = p1_q;
               end
               PRE1: begin
                  state_n = PRE2;
                  tdata_n = P0;
               end
               PRE2: state_n = PRE3;
               PRE3: begin
                  cons = NUM_ZEROS == 0;
                  state_n = cons ? DATA : ZEROS;
                  tdata_n = cons ? to_iq(head) : '0;
               end
               ZEROS: begin
                  cons = sym == ZLAST;
                  state_n = cons ? DATA : ZEROS;
                  sym_n = cons ? 32'd0 : sym + 32'd1;
                  tdata_n = cons ? to_iq(head) : '0;
               end
               DATA: begin
                  cons = sym != len_q - 32'd1;
                  state_n = cons ? DATA : IDLE;
                  sym_n = cons ? sym + 32'd1 : 32'd0;
                  tdata_n = cons ? to_iq(head) : '0;
                  tvalid_n = cons || FILL;
                  busy_n = cons;
               end
               default: state_n = IDLE;
            endcase
      end
      tlast_n = state_n == DATA && samp_n == n_q - 32'd1 && sym_n == len_q - 32'd1;
      // At most two symbols buffered or in flight, which sustains one symbol per beat at N=1.
      occ = cnt + {1'b0, pend};
      bram_en = state != IDLE && rd_cnt < len_q && (occ < 2'd2 || cons);
      bram_addr = rd_cnt[BRAM_BITDEPTH-1:0];
   end

   always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn)
      if (!m00_axis_aresetn) begin
         state <= IDLE;
         samp <= '0;
         sym <= '0;
         n_q <= '0;
         len_q <= '0;
         p1_q <= '0;
         rd_cnt <= '0;
         go <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         m00_axis_tvalid <= 1'b0;
         m00_axis_tlast <= 1'b0;
         m00_axis_tdata <= '0;
         pend <= 1'b0;
         cnt <= '0;
         b0 <= '0;
         b1 <= '0;
      end else begin
         state <= state_n;
         samp <= samp_n;
         sym <= sym_n;
         n_q <= n_n;
         len_q <= len_n;
         p1_q <= p1_n;
         rd_cnt <= state_n == IDLE ? 32'd0 : rd_cnt + {31'd0, bram_en};
         go <= go_n;
         busy <= busy_n;
         done <= done_n;
         m00_axis_tvalid <= tvalid_n;
         m00_axis_tlast <= tlast_n;
         m00_axis_tdata <= tdata_n;
         pend <= bram_en;
         cnt <= cnt + {1'b0, pend} - {1'b0, cons};
         b0 <= cons ? (cnt == 2'd2 ? b1 : bram_douta) : (pend && cnt == 2'd0 ? bram_douta : b0);
         b1 <= (cons || (pend && cnt != 2'd0)) ? bram_douta : b1;
      end
endmodule

// File: doc/qpsk_packet_writer.md
# qpsk_packet_writer

Transmit-side framer for the QPSK link. On a start pulse it reads 2-bit symbols from a BRAM and emits one AXI-Stream frame of 32-bit I/Q samples: a four-point preamble (P0, P1, P2, P3), a run of zero symbols, then the mapped data symbols. Every symbol is held for `num_samples` beats. The frame matches exactly what the packet receiver searches for. The block sits between the symbol BRAM and the DAC-side stream, and drives TLAST on the final beat of each frame.

## Interface
- `C_M00_AXIS_TDATA_WIDTH`, 32, stream width; {I[31:16], Q[15:0]}, both signed.
- `BRAM_BITDEPTH`, 16, BRAM address width.
- `BRAM_BITWIDTH`, 2, symbol width.
- `AMPLITUDE`, 16384, signed magnitude of P0 and data constellation points.
- `NUM_ZEROS`, 4, zero symbols between P3 and data.
- `m00_axis_aclk`  in  1  the only clock.
- `m00_axis_aresetn`  in  1  reset; asynchronous, active-low.
- `m00_axis_tready`  in  1  downstream ready.
- `m00_axis_tvalid`  out  1  sample valid.
- `m00_axis_tlast`  out  1  last beat of frame.
- `m00_axis_tdata`  out  32  {I,Q} sample.
- `m00_axis_tstrb`  out  4  constant 4'hF.
- `bram_addr`  out  BRAM_BITDEPTH  symbol read address.
- `bram_en`  out  1  read enable.
- `bram_douta`  in  BRAM_BITWIDTH  symbol; valid exactly 1 cycle after addr/en.
- `start`  in  1  one-cycle frame request.
- `num_samples`  in  32  beats per symbol; 0 is treated as 1.
- `data_len`  in  32  data symbols per frame.
- `preamble_p1`  in  32  {I,Q} of P1 (P0 rotated by the expected phase difference; computed by software).
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse after the TLAST handshake.

## Operation
- States: IDLE, PRE0, PRE1, PRE2, PRE3, ZEROS, DATA.
- IDLE accepts `start` only when `data_len != 0`. On accept:
  - `num_samples`, `data_len` and `preamble_p1` are latched.
  - `busy` is set and the state moves to PRE0.
- `start` while busy is ignored. Inputs changing mid-frame have no effect.
- Sample values:
  - PRE0, PRE2, PRE3: {+AMPLITUDE, 0}.
  - PRE1: latched P1.
  - ZEROS: {0, 0}.
- DATA mapping, Gray: I = sym[1] ? −AMPLITUDE : +AMPLITUDE; Q = sym[0] ? −AMPLITUDE : +AMPLITUDE.
- Sample counter and symbol counter advance only on `tvalid && tready`.
- A state or symbol ends on the handshake where sample counter = N−1, with N the effective `num_samples`.
- ZEROS lasts NUM_ZEROS symbols.
- DATA reads addresses 0 … data_len−1 in order, with no wrap. Addresses ≥ 2^BRAM_BITDEPTH are truncated.
- Reads are prefetched so symbol k+1 is registered before symbol k ends. The prefetch address is issued no later than ZEROS for address 0.
- TLAST is 1 only on the final beat of the last data symbol.
- After the TLAST handshake: `busy` clears, `done` pulses, state returns to IDLE.
- Frame length is exactly N·(4 + NUM_ZEROS + data_len) beats.

## Timing
- Reset values, applied immediately on reset assertion:
  - tvalid 0, tlast 0, tdata 0, tstrb 4'hF.
  - bram_addr 0, bram_en 0, busy 0, done 0.
  - state IDLE, all counters 0.
- A reset mid-frame discards the frame: no TLAST, no `done`.
- The first beat (P0) has tvalid high on the cycle after `start` is sampled.
- Stream handshake:
  - Once tvalid is high it stays high, with tdata and tlast stable, until the handshake.
  - tvalid never depends combinationally on tready.
- With tready held high the frame is gap-free: one beat per cycle for any N ≥ 1, including N = 1 with the 1-cycle BRAM latency.
- Backpressure never loses, repeats or reorders symbols. bram_en may deassert during stalls.
- `done` is asserted on the cycle after the TLAST handshake.
- A `start` on that same cycle is accepted (back-to-back frames, one idle cycle).

## Configuration
- `PACKET_WRITER_IDLE_FILL_EN` defined:
  - In IDLE the block drives tvalid = 1, tdata = 0, tlast = 0, keeping the DAC stream continuous.
  - An accepted `start` takes effect at the next beat boundary. Any pending fill beat completes its handshake first, then P0 follows.
- Undefined: tvalid = 0 in IDLE.

## Test plan
- data_len=3, N=2, tready=1, BRAM {2'b00, 2'b01, 2'b11}, preamble_p1=32'h0000_4000 → 22 beats:
  - 4000_0000 ×2, 0000_4000 ×2, 4000_0000 ×4, 0000_0000 ×8;
  - then 4000_4000 ×2, 4000_C000 ×2, C000_C000 ×2;
  - TLAST only on beat 22, `done` one cycle later.
- N=1, data_len=8, tready=1 → 16 beats on 16 consecutive cycles, no bubbles, symbols in address order 0–7.
- Same frame as the first test with pseudo-random 50% tready → identical beat sequence; tdata and tlast stable whenever tvalid && !tready.
- `start` pulsed mid-DATA → ignored, frame length unchanged; `start` with data_len=0 → no output, busy stays 0.
- Reset asserted during DATA → tvalid, busy and tlast drop immediately; the next `start` yields a complete frame beginning at P0.
- With `PACKET_WRITER_IDLE_FILL_EN`:
  - IDLE emits zeros with tvalid=1;
  - after `start`, P0 follows the next fill handshake;
  - without the macro, tvalid=0 in IDLE.
